multicycle_alu: RTL and testbench

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/multicycle_alu.sv | 132 +++++++++++++
 tb/tb_multicycle_alu.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arith ops plus an iterative shift-add multiply.
// Results are registered at completion and held until the next completion.
module multicycle_alu #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             invalid_o
);

    localparam int unsigned CntW = $clog2(MUL_CYCLES + 1);

    localparam logic [3:0] OpAnd = 4'h0;
    localparam logic [3:0] OpOr  = 4'h1;
    localparam logic [3:0] OpAdd = 4'h2;
    localparam logic [3:0] OpSub = 4'h6;
    localparam logic [3:0] OpSlt = 4'h7;
    localparam logic [3:0] OpMul = 4'hA;

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              zero_q, zero_d;
    logic              invalid_q, invalid_d;

    logic [WIDTH-1:0]  alu_res;
    logic              alu_valid;
    logic [WIDTH-1:0]  acc_step;
    logic              accept;

    always_comb begin
        alu_res   = '0;
        alu_valid = 1'b1;
        case (ctrl_i)
            OpAnd:   alu_res = src1_i & src2_i;
            OpOr:    alu_res = src1_i | src2_i;
            OpAdd:   alu_res = src1_i + src2_i;
            OpSub:   alu_res = src1_i - src2_i;
            OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            default: alu_valid = 1'b0;
        endcase
    end

    assign accept   = start_i && (state_q != StMul);
    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        result_d  = result_q;
        zero_d    = zero_q;
        invalid_d = invalid_q;
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (accept) begin
                    if (ctrl_i == OpMul) begin
                        state_d  = StMul;
                        cnt_d    = '0;
                        acc_d    = '0;
                        mcand_d  = src1_i;
                        mplier_d = src2_i;
                    end else begin
                        state_d   = StDone;
                        result_d  = alu_res;
                        zero_d    = (alu_res == '0);
                        invalid_d = !alu_valid;
                    end
                end
            end
            StMul: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == CntW'(MUL_CYCLES - 1)) begin
                    state_d   = StDone;
                    result_d  = acc_step;
                    zero_d    = (acc_step == '0);
                    invalid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            invalid_q <= invalid_d;
        end
    end

    assign busy_o    = (state_q == StMul);
    assign done_o    = (state_q == StDone);
    assign result_o  = result_q;
    assign zero_o    = zero_q;
    assign invalid_o = invalid_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu: inputs driven and outputs sampled on the falling edge.
module tb_multicycle_alu;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   ctrl = 4'h0;
    logic [W-1:0] src1 = '0;
    logic [W-1:0] src2 = '0;
    logic         busy, done, zero, invalid;
    logic [W-1:0] result;

    int vectors = 0;
    int miscompares = 0;

    multicycle_alu #(.WIDTH(W), .MUL_CYCLES(W)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .ctrl_i    (ctrl),
        .src1_i    (src1),
        .src2_i    (src2),
        .busy_o    (busy),
        .done_o    (done),
        .result_o  (result),
        .zero_o    (zero),
        .invalid_o (invalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic d, input logic [W-1:0] r,
                              input logic z, input logic inv);
        check({tag, ".done"}, {31'b0, done}, {31'b0, d});
        check({tag, ".busy"}, {31'b0, busy}, 32'd0);
        check({tag, ".result"}, result, r);
        check({tag, ".zero"}, {31'b0, zero}, {31'b0, z});
        check({tag, ".invalid"}, {31'b0, invalid}, {31'b0, inv});
    endtask

    // Drive a request before a rising edge and sample one cycle later on the falling edge.
    task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        ctrl  = c;
        src1  = a;
        src2  = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        int done_k;
        logic both_seen;

        // Reset state
        #12;
        check_outs("reset", 1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // ADD overflow wraps
        issue(4'h2, 32'h7FFF_FFFF, 32'h1);
        check_outs("add", 1'b1, 32'h8000_0000, 1'b0, 1'b0);
        @(negedge clk);
        check_outs("add_hold", 1'b0, 32'h8000_0000, 1'b0, 1'b0);

        issue(4'h6, 32'd5, 32'd5);
        check_outs("sub", 1'b1, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        issue(4'h7, 32'hFFFF_FFFF, 32'h1);
        check_outs("slt_neg", 1'b1, 32'h1, 1'b0, 1'b0);
        @(negedge clk);
        issue(4'h7, 32'h1, 32'hFFFF_FFFF);
        check_outs("slt_pos", 1'b1, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        issue(4'h0, 32'hF0F0_1234, 32'hFF00_FF0F);
        check_outs("and", 1'b1, 32'hF000_1204, 1'b0, 1'b0);
        @(negedge clk);

        // MUL -3 * 7 with stray starts and operand changes mid-flight
        issue(4'hA, 32'hFFFF_FFFD, 32'd7);
        busy_cnt  = 0;
        done_k    = 0;
        both_seen = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 2) check("mul_result_held", result, 32'hF000_1204);
            if (k == 5) begin
                start = 1'b1; ctrl = 4'h2; src1 = 32'h1; src2 = 32'h1;
            end
            if (k == 6) begin
                start = 1'b0; src1 = 32'h0; src2 = 32'h0;
            end
            if (busy) busy_cnt++;
            if (busy && done) both_seen = 1'b1;
            if (done) begin
                done_k = k;
                break;
            end
            @(negedge clk);
        end
        check("mul_busy_cycles", busy_cnt, 32'd32);
        check("mul_done_latency", done_k, 32'd33);
        check("mul_busy_and_done", {31'b0, both_seen}, 32'd0);
        check_outs("mul", 1'b1, 32'hFFFF_FFEB, 1'b0, 1'b0);
        @(negedge clk);
        check_outs("mul_pulse", 1'b0, 32'hFFFF_FFEB, 1'b0, 1'b0);

        // Invalid code, then back-to-back OR issued in the DONE cycle
        issue(4'hE, 32'h1234, 32'h5678);
        check_outs("invalid", 1'b1, 32'h0, 1'b1, 1'b1);
        issue(4'h1, 32'hF0, 32'h0F);
        check_outs("b2b_or", 1'b1, 32'hFF, 1'b0, 1'b0);
        @(negedge clk);
        check_outs("b2b_pulse", 1'b0, 32'hFF, 1'b0, 1'b0);

        // Reset abort at MUL iteration 10
        issue(4'hA, 32'd3, 32'd5);
        for (int k = 1; k < 10; k++) @(negedge clk);
        check("abort_busy_pre", {31'b0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        check_outs("abort", 1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        done_k = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) done_k = k;
        end
        check("abort_no_done", done_k, 32'd0);
        issue(4'h2, 32'd2, 32'd3);
        check_outs("post_abort_add", 1'b1, 32'd5, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
